contador_vagas: RTL and testbench

//  Free-space counter for the parking-space management system; sits directly upstream of the 7-seg decoders.

---
 rtl/contador_vagas_if.sv | 31 +++
 rtl/contador_vagas.sv | 159 +++++++++++++++
 tb/tb_contador_vagas.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/contador_vagas_if.sv
// Sensor inputs and display/status outputs of the free-space counter.
// The counter sits on the slave side; whoever drives the sensors uses master.
interface contador_vagas_if;
    logic       sensor_entrada;
    logic       sensor_saida;
    logic [3:0] vagas_dez;
    logic [3:0] vagas_uni;
    logic       lotado;
    logic       vazio;
    logic       erro;

    modport master (
        output sensor_entrada,
        output sensor_saida,
        input  vagas_dez,
        input  vagas_uni,
        input  lotado,
        input  vazio,
        input  erro
    );

    modport slave (
        input  sensor_entrada,
        input  sensor_saida,
        output vagas_dez,
        output vagas_uni,
        output lotado,
        output vazio,
        output erro
    );
endinterface

// File: rtl/contador_vagas.sv
// Parking free-space counter: synchronises and debounces the entry/exit sensors
// and keeps a two-digit BCD free count with full/empty flags and a reject pulse.
module contador_vagas #(
    parameter int unsigned TOTAL_VAGAS     = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    contador_vagas_if.slave  bus
);

    localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
    localparam logic [3:0]     TotDez  = 4'(TOTAL_VAGAS / 10);
    localparam logic [3:0]     TotUni  = 4'(TOTAL_VAGAS % 10);

    localparam logic [1:0] Estavel0 = 2'd0;
    localparam logic [1:0] Conta1   = 2'd1;
    localparam logic [1:0] Estavel1 = 2'd2;
    localparam logic [1:0] Conta0   = 2'd3;

    // Channel 0 = entrada, channel 1 = saida.
    logic [1:0]      raw;
    logic [1:0]      meta_q, sync_q;
    logic [1:0]      filt_q, filt_d, filt_prev_q;
    logic [1:0]      st_q [2];
    logic [1:0]      st_d [2];
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
    logic [1:0]      ev;

    assign raw = {bus.sensor_saida, bus.sensor_entrada};
    assign ev  = filt_q & ~filt_prev_q;

    // cnt holds the number of consecutive stable cycles seen so far, including
    // the one that left the stable state.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]   = st_q[c];
            cnt_d[c]  = cnt_q[c];
            filt_d[c] = filt_q[c];
            case (st_q[c])
                Estavel0: begin
                    if (sync_q[c]) begin
                        if (CntMax == CntW'(1)) begin
                            st_d[c]   = Estavel1;
                            filt_d[c] = 1'b1;
                        end else begin
                            st_d[c]  = Conta1;
                            cnt_d[c] = CntW'(1);
                        end
                    end
                end
                Conta1: begin
                    if (!sync_q[c]) begin
                        st_d[c] = Estavel0;
                    end else if (cnt_q[c] + CntW'(1) == CntMax) begin
                        st_d[c]   = Estavel1;
                        filt_d[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CntW'(1);
                    end
                end
                Estavel1: begin
                    if (!sync_q[c]) begin
                        if (CntMax == CntW'(1)) begin
                            st_d[c]   = Estavel0;
                            filt_d[c] = 1'b0;
                        end else begin
                            st_d[c]  = Conta0;
                            cnt_d[c] = CntW'(1);
                        end
                    end
                end
                Conta0: begin
                    if (sync_q[c]) begin
                        st_d[c] = Estavel1;
                    end else if (cnt_q[c] + CntW'(1) == CntMax) begin
                        st_d[c]   = Estavel0;
                        filt_d[c] = 1'b0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CntW'(1);
                    end
                end
                default: st_d[c] = Estavel0;
            endcase
        end
    end

    logic [3:0] dez_q, dez_d, uni_q, uni_d;
    logic       lotado_q, lotado_d, vazio_q, vazio_d, erro_q, erro_d;

    // Simultaneous entry and exit cancel out, even at the limits.
    always_comb begin
        dez_d  = dez_q;
        uni_d  = uni_q;
        erro_d = 1'b0;
        if (ev[0] && !ev[1]) begin
            if (lotado_q) begin
                erro_d = 1'b1;
            end else if (uni_q == 4'd0) begin
                uni_d = 4'd9;
                dez_d = dez_q - 4'd1;
            end else begin
                uni_d = uni_q - 4'd1;
            end
        end else if (ev[1] && !ev[0]) begin
            if (vazio_q) begin
                erro_d = 1'b1;
            end else if (uni_q == 4'd9) begin
                uni_d = 4'd0;
                dez_d = dez_q + 4'd1;
            end else begin
                uni_d = uni_q + 4'd1;
            end
        end
        lotado_d = (dez_d == 4'd0) && (uni_d == 4'd0);
        vazio_d  = (dez_d == TotDez) && (uni_d == TotUni);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            for (int c = 0; c < 2; c++) begin
                st_q[c]  <= Estavel0;
                cnt_q[c] <= '0;
            end
            dez_q    <= TotDez;
            uni_q    <= TotUni;
            lotado_q <= 1'b0;
            vazio_q  <= 1'b1;
            erro_q   <= 1'b0;
        end else begin
            meta_q      <= raw;
            sync_q      <= meta_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            for (int c = 0; c < 2; c++) begin
                st_q[c]  <= st_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            dez_q    <= dez_d;
            uni_q    <= uni_d;
            lotado_q <= lotado_d;
            vazio_q  <= vazio_d;
            erro_q   <= erro_d;
        end
    end

    assign bus.vagas_dez = dez_q;
    assign bus.vagas_uni = uni_q;
    assign bus.lotado    = lotado_q;
    assign bus.vazio     = vazio_q;
    assign bus.erro      = erro_q;

endmodule

// File: tb/tb_contador_vagas.sv
// Self-checking bench for contador_vagas: directed vector table, hand-written
// glitch/reset sequences and a randomized run against a free-count model.
module tb_contador_vagas;

    localparam int Total = 12;
    localparam int Deb   = 4;
    localparam int Lat   = 2 + Deb + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    contador_vagas_if bus ();

    contador_vagas #(
        .TOTAL_VAGAS     (Total),
        .DEBOUNCE_CYCLES (Deb)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic ent;
        logic sai;
        int   free;
        int   err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   free_m;

    function automatic void add(input logic e, input logic s, input int f, input int r);
        vec_t v;
        v.ent = e; v.sai = s; v.free = f; v.err = r;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int shown();
        return int'(bus.vagas_dez) * 10 + int'(bus.vagas_uni);
    endfunction

    task automatic chk_state(input string tag, input int free, input int err);
        chk({tag, " dez"}, int'(bus.vagas_dez), free / 10);
        chk({tag, " uni"}, int'(bus.vagas_uni), free % 10);
        chk({tag, " lotado"}, int'(bus.lotado), (free == 0) ? 1 : 0);
        chk({tag, " vazio"}, int'(bus.vazio), (free == Total) ? 1 : 0);
        chk({tag, " erro"}, int'(bus.erro), err);
    endtask

    // Free-count rules at the level of whole cars.
    function automatic void model(input logic e, input logic s, input int prev,
                                  output int nf, output int ne);
        nf = prev;
        ne = 0;
        if (e && !s) begin
            if (prev == 0) ne = 1; else nf = prev - 1;
        end else if (s && !e) begin
            if (prev == Total) ne = 1; else nf = prev + 1;
        end
    endfunction

    task automatic apply_event(input logic ent, input logic sai, input int prev, input int free,
                               input int err, input int hold, input string tag);
        @(negedge clk);
        bus.sensor_entrada = ent;
        bus.sensor_saida   = sai;
        repeat (Lat - 1) @(posedge clk);
        #1 chk({tag, " early"}, shown(), prev);
        @(posedge clk);
        #1 chk_state(tag, free, err);
        @(posedge clk);
        #1 chk({tag, " erro once"}, int'(bus.erro), 0);
        chk({tag, " held"}, shown(), free);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.sensor_entrada = 1'b0;
        bus.sensor_saida   = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk({tag, " settled"}, shown(), free);
        chk({tag, " settled erro"}, int'(bus.erro), 0);
    endtask

    task automatic glitch(input logic on_sai, input int len, input int reps, input int free,
                          input string tag);
        for (int i = 0; i < reps; i++) begin
            @(negedge clk);
            if (on_sai) bus.sensor_saida = 1'b1; else bus.sensor_entrada = 1'b1;
            repeat (len) @(negedge clk);
            bus.sensor_entrada = 1'b0;
            bus.sensor_saida   = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(posedge clk);
        #1 chk_state(tag, free, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int nf, ne;
        bus.sensor_entrada = 1'b0;
        bus.sensor_saida   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_state("in reset", Total, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_state("after reset", Total, 0);

        glitch(1'b0, Deb - 1, 5, Total, "short entry pulses");
        apply_event(1'b1, 1'b0, 12, 11, 0, 12, "long entry");

        for (int i = 10; i >= 0; i--) add(1'b1, 1'b0, i, 0);
        add(1'b1, 1'b0, 0, 1);
        add(1'b1, 1'b1, 0, 0);
        for (int i = 1; i <= 12; i++) add(1'b0, 1'b1, i, 0);
        add(1'b0, 1'b1, 12, 1);
        add(1'b1, 1'b1, 12, 0);
        for (int i = 11; i >= 5; i--) add(1'b1, 1'b0, i, 0);
        add(1'b1, 1'b1, 5, 0);
        add(1'b0, 1'b1, 6, 0);
        add(1'b0, 1'b1, 7, 0);

        prev = 11;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_event(vecs[i].ent, vecs[i].sai, prev, vecs[i].free, vecs[i].err, 3,
                        $sformatf("vec%0d", i));
            prev = vecs[i].free;
        end

        // Reset while the entry filter is still counting, at count 07.
        @(negedge clk);
        bus.sensor_entrada = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.sensor_entrada = 1'b0;
        #1 chk_state("mid-debounce reset", Total, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1 chk_state("after mid reset", Total, 0);

        free_m = Total;
        for (int k = 0; k < 60; k++) begin
            int r;
            logic e, s;
            r = $urandom_range(0, 9);
            if (r < 8) begin
                e = (r < 5) || (r == 7);
                s = (r >= 5);
                model(e, s, free_m, nf, ne);
                apply_event(e, s, free_m, nf, ne, $urandom_range(0, 10),
                            $sformatf("rnd%0d", k));
                free_m = nf;
            end else begin
                glitch(1'($urandom_range(0, 1)), $urandom_range(1, Deb - 1), 2, free_m,
                       $sformatf("rnd glitch%0d", k));
            end
        end

        do_reset();
        @(posedge clk);
        #1 chk_state("final reset", Total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
